// File: rtl/dec_ram_pp.sv
// dec_ram_pp: two-bank ping-pong buffer for hard-decision words.
// The writer fills one bank and closes the frame with wr_done. The reader drains
// the other bank and hands it back with rd_done. Per-bank full flags keep the two
// sides from touching the same bank.
module dec_ram_pp #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_done,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_done,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic [1:0]            occupancy,
  output logic [1:0]            err
);

  logic [DATA_WIDTH-1:0] mem [0:1][0:RAM_DEPTH-1];

  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       wr_ok;
  logic       wr_close;
  logic       rd_ok;
  logic       rd_release;
  logic       wr_in_range;
  logic       rd_in_range;

  assign wr_ready    = !full[wr_ptr];
  assign rd_ready    = full[rd_ptr];
  assign wr_bank     = wr_ptr;
  assign rd_bank     = rd_ptr;

  assign wr_in_range = (32'(wr_addr) < 32'(RAM_DEPTH));
  assign rd_in_range = (32'(rd_addr) < 32'(RAM_DEPTH));

  assign wr_ok       = wr_en   && wr_ready;
  assign wr_close    = wr_done && wr_ready;
  assign rd_ok       = rd_en   && rd_ready;
  assign rd_release  = rd_done && rd_ready;

  // Next full flags. A close and a release always hit different banks, because the
  // write bank is empty and the read bank is full.
  always_comb begin
    full_nxt = full;
    if (wr_close)   full_nxt[wr_ptr] = 1'b1;
    if (rd_release) full_nxt[rd_ptr] = 1'b0;
  end

  // Bank pointers, full flags, occupancy and the sticky error bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= 2'b00;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
      err       <= 2'b00;
    end else begin
      full      <= full_nxt;
      occupancy <= {1'b0, full_nxt[0]} + {1'b0, full_nxt[1]};
      if (wr_close)   wr_ptr <= ~wr_ptr;
      if (rd_release) rd_ptr <= ~rd_ptr;
      if ((wr_en || wr_done) && !wr_ready) err[0] <= 1'b1;
      if ((rd_en || rd_done) && !rd_ready) err[1] <= 1'b1;
    end
  end

  // Memory write port. Memory is not reset. A write that arrives in a reset cycle
  // is discarded.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok && wr_in_range)
      mem[wr_ptr][wr_addr] <= wr_data;
  end

  // Registered read port. Data follows one cycle after an accepted read.
  // Out-of-range reads still complete, but they return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rd_ok) begin
      rd_valid <= 1'b1;
      rd_data  <= rd_in_range ? mem[rd_ptr][rd_addr] : '0;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule
